// File: rtl/conf_int_dot_acc__truncated.sv
// conf_int_dot_acc__truncated: streaming dot-product accumulator with
// truncated operands. The NAB low bits of each operand are dropped before
// the multiply. Only the low W bits of each product are kept, and the sum
// is accumulated W bits wide. Any lost high bits set a sticky overflow flag.
// Build option: define CONF_INT_DOT_ACC_SAT_EN to saturate the accumulator
// to all-ones on overflow. The default build wraps modulo 2^W.
module conf_int_dot_acc__truncated #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int NAB                = 4,
    parameter int LEN_BITWIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_BITWIDTH-1:0]       len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] out_data,
    output logic                          overflow,
    output logic                          busy
);
    localparam int W = DATA_PATH_BITWIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Clears the NAB least-significant operand bits; works for NAB = 0 too.
    localparam logic [W-1:0] KEEP_MASK = ~((W'(1) << NAB) - W'(1));

    logic [1:0]              state;
    logic [W-1:0]            acc;
    logic [LEN_BITWIDTH-1:0] count;
    logic                    ovf;

    logic [W-1:0]   a_t;
    logic [W-1:0]   b_t;
    logic [2*W-1:0] prod;
    logic [W:0]     sum;
    logic           term_ovf;
    logic [W-1:0]   acc_next;

`ifdef CONF_INT_DOT_ACC_SAT_EN
    // Clamp to all-ones once this result has overflowed.
    function automatic logic [W-1:0] saturate(input logic [W-1:0] s, input logic of);
        return of ? {W{1'b1}} : s;
    endfunction
`endif

    // Truncate, multiply, and add one term to the accumulator.
    // Overflow is flagged when the sum carries out of W bits or when the
    // product has any nonzero bit above the low W bits.
    always_comb begin
        a_t      = a & KEEP_MASK;
        b_t      = b & KEEP_MASK;
        prod     = {{W{1'b0}}, a_t} * {{W{1'b0}}, b_t};
        sum      = {1'b0, acc} + {1'b0, prod[W-1:0]};
        term_ovf = sum[W] | (|prod[2*W-1:W]);
`ifdef CONF_INT_DOT_ACC_SAT_EN
        acc_next = saturate(sum[W-1:0], term_ovf | ovf);
`else
        acc_next = sum[W-1:0];
`endif
    end

    // Control FSM and accumulator. Reset also discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (len != '0) begin
                            count <= len;
                            state <= ST_ACC;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        ovf   <= ovf | term_ovf;
                        count <= count - LEN_BITWIDTH'(1);
                        if (count == LEN_BITWIDTH'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_data  = acc;
    assign overflow  = ovf;

endmodule

// File: tb/tb_conf_int_dot_acc__truncated.sv
// Testbench for conf_int_dot_acc__truncated (W=16, NAB=4, LEN_BITWIDTH=8).
// It has a table of fixed vectors, hand-written corner-case sequences, and
// random runs checked against an arithmetic reference model.
module tb_conf_int_dot_acc__truncated;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] op_a [16];
    logic [15:0] op_b [16];

    typedef struct {
        int          n;
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [6];

    conf_int_dot_acc__truncated #(
        .DATA_PATH_BITWIDTH(16),
        .NAB(4),
        .LEN_BITWIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .overflow(overflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: truncate the operands, take the product mod 2^16, and
    // accumulate. Any lost high bits mark the result as overflowed.
    task automatic ref_dot(input int n, output logic [15:0] d, output logic o);
        longint acc_m = 0;
        longint at, bt, p;
        bit ov = 0;
        for (int i = 0; i < n; i++) begin
            at = (longint'(op_a[i]) / 16) * 16;
            bt = (longint'(op_b[i]) / 16) * 16;
            p  = at * bt;
            if (p >= 65536) ov = 1;
            acc_m = acc_m + (p % 65536);
            if (acc_m >= 65536) ov = 1;
            acc_m = acc_m % 65536;
`ifdef CONF_INT_DOT_ACC_SAT_EN
            if (ov) acc_m = 65535;
`endif
        end
        d = 16'(acc_m);
        o = ov;
    endtask

    // One complete transaction: start, n transfers, then the result handoff.
    task automatic run_seq(input int n, input bit gaps, input bit early_rdy,
                           input bit inj_start, output logic [15:0] d, output logic o);
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        start = 1'b1; len = 8'(n);
        step();
        start = 1'b0; len = 8'd0;
        check("acc_in_ready", 32'(in_ready), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
                check("gap_in_ready", 32'(in_ready), 32'd1);
            end
            if (inj_start && i == 1) begin
                start = 1'b1; len = 8'd9;
            end
            if (early_rdy && i == n - 1) out_ready = 1'b1;
            in_valid = 1'b1; a = op_a[i]; b = op_b[i];
            step();
            start = 1'b0; len = 8'd0;
            if (i < n - 1) check("mid_out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        d = out_data;
        o = overflow;
        if (!early_rdy) begin
            out_ready = 1'b1;
        end
        step();
        out_ready = 1'b0;
        check("handoff_busy", 32'(busy), 32'd0);
        check("handoff_out_valid", 32'(out_valid), 32'd0);
    endtask

    function automatic vec_t mk(input int n,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2,
                                input logic [15:0] d, input logic o);
        vec_t v;
        v.n = n;
        v.va[0] = a0; v.vb[0] = b0;
        v.va[1] = a1; v.vb[1] = b1;
        v.va[2] = a2; v.vb[2] = b2;
        v.exp_data = d;
        v.exp_ovf = o;
        return v;
    endfunction

    initial begin
        logic [15:0] d, md;
        logic        o, mo;
        int          n;

`ifdef CONF_INT_DOT_ACC_SAT_EN
        vecs[1] = mk(2, 16'h0FF0, 16'h0010, 16'h0FF0, 16'h0010, 0, 0, 16'hFFFF, 1'b1);
        vecs[4] = mk(1, 16'h1000, 16'h0010, 0, 0, 0, 0, 16'hFFFF, 1'b1);
`else
        vecs[1] = mk(2, 16'h0FF0, 16'h0010, 16'h0FF0, 16'h0010, 0, 0, 16'hFE00, 1'b1);
        vecs[4] = mk(1, 16'h1000, 16'h0010, 0, 0, 0, 0, 16'h0000, 1'b1);
`endif
        vecs[0] = mk(2, 16'h0013, 16'h0025, 16'h0100, 16'h0003, 0, 0, 16'h0200, 1'b0);
        vecs[2] = mk(1, 16'h0010, 16'h0010, 0, 0, 0, 0, 16'h0100, 1'b0);
        vecs[3] = mk(3, 16'h0020, 16'h0030, 16'h001F, 16'h001F, 16'h0040, 16'h0040, 16'h1700, 1'b0);
        vecs[5] = mk(1, 16'h000F, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 1'b0);

        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        a = 16'h0; b = 16'h0; out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Fixed vectors
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < vecs[k].n; i++) begin
                op_a[i] = vecs[k].va[i];
                op_b[i] = vecs[k].vb[i];
            end
            run_seq(vecs[k].n, 1'b0, 1'b0, 1'b0, d, o);
            check($sformatf("vec%0d_data", k), 32'(d), 32'(vecs[k].exp_data));
            check($sformatf("vec%0d_ovf", k), 32'(o), 32'(vecs[k].exp_ovf));
        end

        // A second start during accumulation must be ignored
        op_a[0] = 16'h0030; op_b[0] = 16'h0020;
        op_a[1] = 16'h0110; op_b[1] = 16'h0050;
        op_a[2] = 16'h0010; op_b[2] = 16'h0070;
        ref_dot(3, md, mo);
        run_seq(3, 1'b0, 1'b0, 1'b1, d, o);
        check("ign_start_data", 32'(d), 32'(md));
        check("ign_start_ovf", 32'(o), 32'(mo));

        // out_ready already high on entry to DONE
        run_seq(3, 1'b0, 1'b1, 1'b0, d, o);
        check("early_rdy_data", 32'(d), 32'(md));

        // Backpressure: the result must hold while out_ready stays low
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; a = 16'h0010; b = 16'h0010;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h0100);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_busy", 32'(busy), 32'd0);

        // Zero length goes straight to DONE; operands are never accepted
        start = 1'b1; len = 8'd0; in_valid = 1'b1; a = 16'h0100; b = 16'h0100;
        step();
        start = 1'b0;
        check("zero_out_valid", 32'(out_valid), 32'd1);
        check("zero_out_data", 32'(out_data), 32'd0);
        check("zero_in_ready", 32'(in_ready), 32'd0);
        step();
        check("zero_hold_data", 32'(out_data), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("zero_idle", 32'(busy), 32'd0);

        // Reset in the middle of an accumulation
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1; a = 16'h0100; b = 16'h0020;
        step();
        in_valid = 1'b0;
        check("pre_rst_data", 32'(out_data), 32'h2000);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        step();

        // Random runs against the reference model
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    op_a[i] = 16'($urandom_range(0, 16'h03FF));
                    op_b[i] = 16'($urandom_range(0, 16'h00FF));
                end else begin
                    op_a[i] = 16'($urandom);
                    op_b[i] = 16'($urandom);
                end
            end
            ref_dot(n, md, mo);
            run_seq(n, 1'b1, 1'($urandom_range(0, 1)), 1'b0, d, o);
            check($sformatf("rand%0d_data", r), 32'(d), 32'(md));
            check($sformatf("rand%0d_ovf", r), 32'(o), 32'(mo));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conf_int_dot_acc__truncated.md
CONF_INT_DOT_ACC__TRUNCATED -- requirements
Module: conf_int_dot_acc__truncated

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 16: operand/accumulator width W.
REQ-002 Parameter NAB, default 4: low operand bits dropped before multiply; legal range 0..W-1.
REQ-003 Parameter LEN_BITWIDTH, default 8: width of term-count input.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin new dot product; sampled only in IDLE.
- len  in  LEN_BITWIDTH  number of (a,b) terms; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operand pair.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  accumulated result.
- overflow  out  1  sticky overflow for current result.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 FSM states: IDLE, ACC, DONE, held in one registered state variable.
REQ-006 IDLE: start=1 with len>0 -> ACC, acc<=0, overflow<=0, count<=len; start=1 with len=0 -> DONE, acc<=0, overflow<=0.
REQ-007 in_ready SHALL be 1 exactly in ACC; a transfer occurs on a cycle with in_valid&in_ready.
REQ-008 Per transfer: a_t = {a[W-1:NAB], NAB zeros}, b_t = {b[W-1:NAB], NAB zeros}; term = low W bits of the 2W-bit unsigned product a_t*b_t; sum = acc + term, computed W+1 bits wide.
REQ-009 Accumulator is registered; updated acc is visible on out_data one cycle after the transfer.
REQ-010 sum[W]=1 or any nonzero discarded product bit [2W-1:W] SHALL set overflow, which stays set until the next accepted start or rst.
REQ-011 count decrements per transfer; the transfer with count=1 -> DONE on the next cycle.
REQ-012 DONE: out_valid=1; out_data and overflow held stable until out_valid&out_ready; then -> IDLE.
REQ-013 out_data SHALL equal acc in every state; out_valid=0 outside DONE.
REQ-014 start asserted in ACC or DONE SHALL be ignored; no restart, no state corruption.
REQ-015 In IDLE, in_valid is ignored; no operand is consumed.
REQ-016 Latency: a sequence of len gap-free transfers SHALL yield out_valid in the cycle after the last transfer (throughput one term/cycle).
REQ-017 out_ready high while entering DONE SHALL complete the handoff in the first DONE cycle, returning to IDLE next cycle.

Reset
REQ-018 rst=1 at a clock edge SHALL force state=IDLE, acc=0, count=0, overflow=0, regardless of current state, including mid-ACC or DONE; the in-flight result is discarded.
REQ-019 Reset outputs: in_ready=0, out_valid=0, out_data=0, overflow=0, busy=0.

Configuration
REQ-020 Macro CONF_INT_DOT_ACC_SAT_EN defined: on overflow (REQ-010) acc SHALL saturate to all-ones and remain all-ones for the rest of the sequence.
REQ-021 Macro undefined: acc SHALL wrap modulo 2^W; overflow flagging is identical in both builds.

Verification (W=16, NAB=4, LEN_BITWIDTH=8)
REQ-022 Reset: assert rst for 2 cycles mid-ACC -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=0, busy=0.
REQ-023 Basic: start, len=2; pairs (0x0013,0x0025), (0x0100,0x0003) gap-free -> terms 0x0200 and 0x0000; out_valid the cycle after the 2nd transfer, out_data=0x0200, overflow=0.
REQ-024 Backpressure: len=1, (0x0010,0x0010) -> out_data=0x0100; hold out_ready=0 for 5 cycles -> out_valid and out_data stable; out_ready=1 -> IDLE next cycle.
REQ-025 Zero length: start, len=0 -> DONE next cycle, out_data=0x0000, in_ready stays 0.
REQ-026 Overflow: len=2, (0x0FF0,0x0010) twice -> term 0xFF00 each; with CONF_INT_DOT_ACC_SAT_EN out_data=0xFFFF, without out_data=0xFE00; overflow=1 in both.
REQ-027 Ignored start: pulse start with len=9 during ACC of a len=3 run -> exactly 3 transfers accepted, result matches len=3 reference.
